// File: rtl/fp32_div_iter_if.sv
// rtl/fp32_div_iter_if.sv - handshake bundle for the iterative fp32 divider
// Signals:
//   start  : request, sampled only while the divider is idle
//   A, B   : IEEE-754 single dividend / divisor
//   busy   : operation in flight
//   done   : one-cycle pulse, result valid
//   result : registered quotient, held until the next done
interface fp32_div_iter_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, A, B, input busy, done, result);
  modport slave  (input start, A, B, output busy, done, result);
endinterface

// File: rtl/fp32_div_iter.sv
// rtl/fp32_div_iter.sv - iterative IEEE-754 single-precision divider (restoring, 1 bit/cycle)
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fp32_div_iter_if.slave (start, A, B in; busy, done, result out)
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the
// quotient is truncated. Latency is the same either way.
module fp32_div_iter (
  input  logic           clk,
  input  logic           rst,
  fp32_div_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        result_q;
  logic [4:0]         cnt;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q;
  logic [25:0]        quo_q;
  logic               special_q;
  logic [31:0]        special_res_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Operand classification; denormals are treated as zero.
  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in, special;
  logic [31:0] special_res;

  always_comb begin
    a_exp   = bus.A[30:23];
    b_exp   = bus.B[30:23];
    a_zero  = (a_exp == 8'd0);
    b_zero  = (b_exp == 8'd0);
    a_inf   = (a_exp == 8'hFF) && (bus.A[22:0] == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (bus.B[22:0] == 23'd0);
    a_nan   = (a_exp == 8'hFF) && (bus.A[22:0] != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (bus.B[22:0] != 23'd0);
    sign_in = bus.A[31] ^ bus.B[31];
    special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    special_res = 32'h0;
    if (a_nan || b_nan)                          special_res = 32'h7FFFFFFF;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) special_res = 32'h7FFFFFFF;
    else if (a_zero)                             special_res = {sign_in, 31'h0};
    else if (b_zero)                             special_res = {sign_in, 8'hFF, 23'h0};
    else if (a_inf)                              special_res = {sign_in, 8'hFF, 23'h0};
    else if (b_inf)                              special_res = {sign_in, 31'h0};
  end

  // One restoring step. The partial remainder is always below the divisor
  // after subtraction, so 24 bits hold it before the left shift.
  logic        ge;
  logic [23:0] diff;
  logic [23:0] rem_next;

  always_comb begin
    ge       = (rem_q >= {1'b0, mb_q});
    diff     = rem_q[23:0] - mb_q;
    rem_next = ge ? diff : rem_q[23:0];
  end

  // Normalize, round, and range-check the finished quotient.
  logic [23:0]       mant;
  logic signed [9:0] en;
  logic signed [9:0] ef;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic              round_up;
  logic [31:0]       norm_res;
`ifdef FP_DIV_ROUND_EN
  logic              guard;
  logic              sticky;
`endif

  always_comb begin
    // Quotient lies in [0.5, 2): an MSB of 0 means one left shift is needed.
    mant     = quo_q[25] ? quo_q[25:2] : quo_q[24:1];
    en       = quo_q[25] ? exp_q : exp_q - 10'sd1;
    round_up = 1'b0;
`ifdef FP_DIV_ROUND_EN
    guard    = quo_q[25] ? quo_q[1] : quo_q[0];
    // After the shift the round slot is empty; the remainder still covers it.
    sticky   = (rem_q != 25'd0) | (quo_q[25] & quo_q[0]);
    round_up = guard & (sticky | mant[0]);
`endif
    mant_r = {1'b0, mant} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac = mant_r[23:1];
      ef   = en + 10'sd1;
    end else begin
      frac = mant_r[22:0];
      ef   = en;
    end
    if (ef <= 10'sd0)
      norm_res = {sign_q, 31'h0};
    else if (ef >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'h0};
    else
      norm_res = {sign_q, ef[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= 32'h0;
      cnt           <= 5'd0;
      sign_q        <= 1'b0;
      exp_q         <= 10'sd0;
      mb_q          <= 24'd0;
      rem_q         <= 25'd0;
      quo_q         <= 26'd0;
      special_q     <= 1'b0;
      special_res_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q        <= 1'b1;
            cnt           <= 5'd0;
            sign_q        <= sign_in;
            exp_q         <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
            mb_q          <= {1'b1, bus.B[22:0]};
            rem_q         <= {2'b01, bus.A[22:0]};
            quo_q         <= 26'd0;
            special_q     <= special;
            special_res_q <= special_res;
            // Specials skip the iterations and retire on the very next edge.
            state         <= special ? NORM : DIV;
          end
        end
        DIV: begin
          rem_q <= {rem_next, 1'b0};
          quo_q <= {quo_q[24:0], ge};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd25)
            state <= NORM;
        end
        NORM: begin
          result_q <= special_q ? special_res_q : norm_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp32_div_iter.md
FP32_DIV_ITER -- requirements
Module: fp32_div_iter

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-004 SHALL have port A, input, 32: IEEE-754 single dividend.
REQ-005 SHALL have port B, input, 32: IEEE-754 single divisor.
REQ-006 SHALL have port busy, output, 1: high while an operation is in flight.
REQ-007 SHALL have port done, output, 1: one-cycle pulse; result valid.
REQ-008 SHALL have port result, output, 32: quotient, registered, held until next done.

Function
REQ-009 SHALL classify each operand: exp==0 -> zero (denormals flushed); exp==255, mant==0 -> Inf; exp==255, mant!=0 -> NaN; else normal.
REQ-010 SHALL use sign s = A[31]^B[31] for every zero/Inf result; NaN result SHALL always be 32'h7FFFFFFF.
REQ-011 SHALL resolve specials by priority: any NaN -> NaN; 0/0 or Inf/Inf -> NaN; 0/x -> {s,31'h0}; x/0 -> {s,Inf}; Inf/finite -> {s,Inf}; finite/Inf -> {s,31'h0}.
REQ-012 SHALL implement FSM IDLE, DIV, NORM. IDLE+start -> special ? IDLE with result/done : DIV; DIV -> NORM after 26 iterations; NORM -> IDLE.
REQ-013 SHALL, on accept edge N, capture A/B, signed 10-bit exponent eA-eB+127, mantissas {1,frac}, and assert busy.
REQ-014 SHALL, special case: result and done=1 at edge N+1, busy low from N+1.
REQ-015 SHALL, normal case: restoring division, one quotient bit per cycle, 26 bits (1 integer, 23 frac, guard, round), remainder kept for sticky.
REQ-016 SHALL, in NORM: if quotient MSB==0, shift left 1 and decrement exponent; result and done=1 at edge N+27; busy low from N+27.
REQ-017 SHALL flush to {s,31'h0} when final exponent <=0, and saturate to {s,8'hFF,23'h0} when >=255.
REQ-018 SHALL, on mantissa rounding carry-out, renormalize, increment exponent, re-apply REQ-017.
REQ-019 SHALL ignore start while busy; start in the done cycle SHALL be accepted (state already IDLE).
REQ-020 SHALL keep result unchanged except at a done edge.

Reset
REQ-021 SHALL, on rst, immediately force state IDLE, busy=0, done=0, result=32'h0, iteration counter 0.
REQ-022 SHALL, on rst mid-operation, abort with no done pulse; next start after release SHALL run normally.

Configuration
REQ-023 SHALL, with FP_DIV_ROUND_EN defined, round to nearest-even using guard, round and sticky (nonzero remainder OR round bit).
REQ-024 SHALL, without FP_DIV_ROUND_EN, truncate (guard/round/sticky discarded); latency unchanged.

Verification
REQ-025 SHALL test 40C00000/40000000 (6/2) -> result 40400000, done at edge N+27, busy high for 27 cycles.
REQ-026 SHALL test 3F800000/40400000 (1/3) -> 3EAAAAAB with FP_DIV_ROUND_EN, 3EAAAAAA without.
REQ-027 SHALL test 3F800000/00000000 -> 7F800000 and BF800000/00000000 -> FF800000, each done at N+1.
REQ-028 SHALL test 0/0, 7F800000/FF800000, and 7FC00000/3F800000 -> 7FFFFFFF each; 00000000/7F800000 -> 00000000.
REQ-029 SHALL test 7F000000/3E800000 -> 7F800000 (overflow) and 00800000/4B000000 -> 00000000 (underflow).
REQ-030 SHALL test rst pulse at cycle 10 of 6/2 -> busy 0, no done; then 6/2 again -> 40400000 at N+27; start held high through done -> back-to-back second op accepted in done cycle.
